// File: rtl/srv_line_fill_pkg.sv
// Shared memory-side definitions for the line-fill controller and the icache:
// FSM state encodings, line geometry and address helpers.
package srv_line_fill_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_RESP = 2'd2
    } fill_state_e;

    localparam int LINE_BYTES  = 16;
    localparam int OFFSET_BITS = 4;

    // Base address of the line containing a byte address.
    function automatic logic [31:0] line_base(input logic [31:0] addr);
        return {addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    endfunction

    // Byte address of word idx inside the line; the offset never carries into the tag bits.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [1:0] idx);
        return {base[31:OFFSET_BITS], idx, 2'b00};
    endfunction

endpackage

// File: rtl/srv_wait_cnt.sv
// Wait-state counter for memory latency models: counts up while inc_i is high,
// clears on clr_i, and flags done_o when the count reaches EXTRA_LAT.
module srv_wait_cnt #(
    parameter int unsigned EXTRA_LAT = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic done_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Next count: clear has priority over increment.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 4'd0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == EXTRA_LAT[3:0]);

endmodule

// File: rtl/srv_line_fill.sv
// Line-fill controller: reads one 128-bit line from the combinational boot ROM
// one word at a time (with optional wait states) and returns it with a one-cycle pulse.
module srv_line_fill
    import srv_line_fill_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int EXTRA_LAT  = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  ext_addr_i,
    input  logic         ext_req_i,
    output logic         ext_rsp_o,
    output logic [127:0] ext_data_o,
    output logic [31:0]  rom_addr_o,
    input  logic [31:0]  rom_data_i,
    output logic         busy_o,
    output logic [15:0]  fill_cnt_o
);

    localparam logic [1:0] LAST_IDX = 2'(LINE_WORDS - 1);

    fill_state_e state_q, state_d;
    logic [31:0] base_q, base_d;
    logic [1:0]  word_idx_q, word_idx_d;
    logic [31:0] rom_addr_q, rom_addr_d;
    logic [15:0] fill_cnt_q, fill_cnt_d;
    logic [31:0] line_q [4];
    logic [3:0]  word_we;
    logic        wait_clr;
    logic        wait_inc;
    logic        wait_done;

    srv_wait_cnt #(
        .EXTRA_LAT (EXTRA_LAT)
    ) u_wait_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (wait_clr),
        .inc_i  (wait_inc),
        .done_o (wait_done)
    );

    // Next-state logic: accept in IDLE, pace word captures in READ, pulse in RESP.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        word_idx_d = word_idx_q;
        rom_addr_d = rom_addr_q;
        fill_cnt_d = fill_cnt_q;
        wait_clr   = 1'b0;
        wait_inc   = 1'b0;
        word_we    = 4'b0000;
        unique case (state_q)
            ST_IDLE: begin
                if (ext_req_i) begin
                    base_d     = line_base(ext_addr_i);
                    rom_addr_d = line_base(ext_addr_i);
                    word_idx_d = 2'd0;
                    wait_clr   = 1'b1;
                    state_d    = ST_READ;
                end
            end
            ST_READ: begin
                if (!wait_done) begin
                    wait_inc = 1'b1;
                end else begin
                    word_we[word_idx_q] = 1'b1;
                    wait_clr            = 1'b1;
                    word_idx_d          = word_idx_q + 2'd1;
                    if (word_idx_q == LAST_IDX) begin
                        // The last word address stays on the ROM bus until the next fill.
                        state_d = ST_RESP;
                    end else begin
                        rom_addr_d = word_addr(base_q, word_idx_q + 2'd1);
                    end
                end
            end
            ST_RESP: begin
                fill_cnt_d = fill_cnt_q + 16'd1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers; reset discards any fill in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            base_q     <= 32'd0;
            word_idx_q <= 2'd0;
            rom_addr_q <= 32'd0;
            fill_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            word_idx_q <= word_idx_d;
            rom_addr_q <= rom_addr_d;
            fill_cnt_q <= fill_cnt_d;
        end
    end

    // Line register: four words, each loaded when its slot is captured.
    always_ff @(posedge clk) begin
        // NOTE: the line storage is reset because ext_data_o must read as zero after reset.
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                line_q[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (word_we[i]) begin
                    line_q[i] <= rom_data_i;
                end
            end
        end
    end

    assign ext_rsp_o  = (state_q == ST_RESP);
    assign busy_o     = (state_q != ST_IDLE);
    assign ext_data_o = {line_q[3], line_q[2], line_q[1], line_q[0]};
    assign rom_addr_o = rom_addr_q;
    assign fill_cnt_o = fill_cnt_q;

endmodule

// File: tb/tb_srv_line_fill.sv
// Self-checking bench for srv_line_fill: two instances (EXTRA_LAT 0 and 2),
// directed scenarios plus randomized fills against a line/latency reference model.
module tb_srv_line_fill;

    localparam int LAT0 = 0;
    localparam int LAT2 = 2;

    logic         clk;
    logic         rst;
    logic [31:0]  ext_addr [2];
    logic         ext_req  [2];
    logic         ext_rsp  [2];
    logic [127:0] ext_data [2];
    logic [31:0]  rom_addr [2];
    logic [31:0]  rom_data [2];
    logic         busy     [2];
    logic [15:0]  fill_cnt [2];

    // Behavioural ROM: word at byte address a is (rom_base + a/4) ^ rom_mask.
    logic [31:0] rom_base;
    logic [31:0] rom_mask;

    int checks;
    int errors;
    logic [15:0] exp_fill [2];

    srv_line_fill #(.LINE_WORDS(4), .EXTRA_LAT(LAT0)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .ext_addr_i (ext_addr[0]),
        .ext_req_i  (ext_req[0]),
        .ext_rsp_o  (ext_rsp[0]),
        .ext_data_o (ext_data[0]),
        .rom_addr_o (rom_addr[0]),
        .rom_data_i (rom_data[0]),
        .busy_o     (busy[0]),
        .fill_cnt_o (fill_cnt[0])
    );

    srv_line_fill #(.LINE_WORDS(4), .EXTRA_LAT(LAT2)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .ext_addr_i (ext_addr[1]),
        .ext_req_i  (ext_req[1]),
        .ext_rsp_o  (ext_rsp[1]),
        .ext_data_o (ext_data[1]),
        .rom_addr_o (rom_addr[1]),
        .rom_data_i (rom_data[1]),
        .busy_o     (busy[1]),
        .fill_cnt_o (fill_cnt[1])
    );

    assign rom_data[0] = (rom_base + {2'b00, rom_addr[0][31:2]}) ^ rom_mask;
    assign rom_data[1] = (rom_base + {2'b00, rom_addr[1][31:2]}) ^ rom_mask;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_model(input logic [31:0] a);
        return (rom_base + (a >> 2)) ^ rom_mask;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete fill on instance sel; checks ROM address sequence, busy,
    // response latency, line contents and the fill counter.
    task automatic run_fill(input int sel, input logic [31:0] a, input bit hijack);
        int lat;
        int cyc;
        logic [31:0]  base;
        logic [127:0] exp_line;
        lat  = (sel == 0) ? LAT0 : LAT2;
        base = a & 32'hFFFF_FFF0;
        for (int k = 0; k < 4; k++) begin
            exp_line[32*k +: 32] = rom_model(base + 32'(4 * k));
        end
        ext_req[sel]  = 1'b1;
        ext_addr[sel] = a;
        step();
        ext_req[sel] = 1'b0;
        cyc = 1;
        while (!ext_rsp[sel] && cyc <= 80) begin
            check("busy_read", busy[sel], 1'b1);
            check("rom_addr", rom_addr[sel], base + 32'(4 * ((cyc - 1) / (lat + 1))));
            if (cyc == 2) ext_addr[sel] = hijack ? 32'h0000_0100 : $urandom;
            step();
            cyc++;
        end
        check("rsp_latency", cyc, 4 * (lat + 1) + 1);
        check("line_data", ext_data[sel], exp_line);
        check("busy_resp", busy[sel], 1'b1);
        exp_fill[sel] = exp_fill[sel] + 16'd1;
        step();
        check("rsp_single", ext_rsp[sel], 1'b0);
        check("busy_after", busy[sel], 1'b0);
        check("fill_cnt", fill_cnt[sel], exp_fill[sel]);
        check("data_hold", ext_data[sel], exp_line);
    endtask

    initial begin
        int first;
        int second;
        int cyc;
        int gap;
        checks   = 0;
        errors   = 0;
        exp_fill[0] = 16'd0;
        exp_fill[1] = 16'd0;
        rom_base = 32'hA000_0000;
        rom_mask = 32'd0;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ext_req[i]  = 1'b0;
            ext_addr[i] = 32'd0;
        end
        step();
        step();

        // Reset values.
        for (int i = 0; i < 2; i++) begin
            check("rst_rsp", ext_rsp[i], 1'b0);
            check("rst_data", ext_data[i], 128'd0);
            check("rst_rom_addr", rom_addr[i], 32'd0);
            check("rst_busy", busy[i], 1'b0);
            check("rst_fill_cnt", fill_cnt[i], 16'd0);
        end

        // Reset wins over a simultaneous request.
        ext_req[0] = 1'b1;
        step();
        rst = 1'b0;
        ext_req[0] = 1'b0;
        check("rst_req_busy", busy[0], 1'b0);
        step();
        check("rst_req_idle", busy[0], 1'b0);

        // Directed fill at 0x24 with the default latency.
        run_fill(0, 32'h0000_0024, 1'b0);
        check("tp1_line", ext_data[0], 128'hA000000B_A000000A_A0000009_A0000008);
        check("tp1_cnt", fill_cnt[0], 16'd1);

        // Three-cycle words on the slow instance.
        run_fill(1, 32'h0000_0000, 1'b0);

        // Address change after acceptance is ignored.
        run_fill(0, 32'h0000_0040, 1'b1);

        // Request held through RESP: back-to-back fills six cycles apart.
        ext_req[0]  = 1'b1;
        ext_addr[0] = 32'h0000_0080;
        step();
        cyc    = 1;
        first  = -1;
        second = -1;
        while (second < 0 && cyc <= 40) begin
            if (ext_rsp[0]) begin
                if (first < 0) first = cyc;
                else begin
                    second = cyc;
                    ext_req[0] = 1'b0;
                end
            end
            if (second < 0) begin
                step();
                cyc++;
            end
        end
        check("hold_first", first, 5);
        check("hold_gap", second - first, 6);
        check("hold_line", ext_data[0],
              {rom_model(32'h8C), rom_model(32'h88), rom_model(32'h84), rom_model(32'h80)});
        exp_fill[0] = exp_fill[0] + 16'd2;
        step();
        check("hold_cnt", fill_cnt[0], exp_fill[0]);
        check("hold_idle", busy[0], 1'b0);

        // Randomized fills on both instances with random ROM contents.
        for (int n = 0; n < 12; n++) begin
            rom_base = $urandom;
            rom_mask = $urandom;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                step();
                check("idle_rsp", ext_rsp[n % 2], 1'b0);
            end
            run_fill(n % 2, $urandom, 1'b0);
        end

        // Reset in the third READ cycle discards the fill.
        ext_req[0]  = 1'b1;
        ext_addr[0] = 32'h0000_0060;
        step();
        ext_req[0] = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_fill[0] = 16'd0;
        exp_fill[1] = 16'd0;
        check("midrst_busy", busy[0], 1'b0);
        check("midrst_data", ext_data[0], 128'd0);
        check("midrst_rsp", ext_rsp[0], 1'b0);
        check("midrst_cnt", fill_cnt[0], 16'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("midrst_no_rsp", ext_rsp[0], 1'b0);
        end
        run_fill(0, 32'h0000_0060, 1'b0);

        // Counter wrap: preload 0xFFFF, one more fill returns it to zero.
        force dut0.fill_cnt_q = 16'hFFFF;
        step();
        release dut0.fill_cnt_q;
        step();
        check("preload_cnt", fill_cnt[0], 16'hFFFF);
        exp_fill[0] = 16'hFFFF;
        run_fill(0, 32'h0000_0010, 1'b0);
        check("wrap_cnt", fill_cnt[0], 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
